gray_codec_pipe: RTL and testbench
==================================

Name: gray_codec_pipe

Overview:
Parametrised, pipelined binary/Gray converter with valid/ready handshake, plus an integrated up/down Gray-code counter.
- The converter handles binary-to-Gray and Gray-to-binary, selected per transaction.
- The counter is used for clock-domain-crossing pointers and test-pattern generation.
- It replaces fixed 4-bit combinational conversion wherever wider or back-pressured paths are needed.

Parameters:
WIDTH, 4, data/counter width in bits (>=2)
CNT_RESET, 0, binary reset/clear value of the counter (< 2^WIDTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transaction present
in_ready  output  1  block accepts input this cycle
in_mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary
in_data  input  WIDTH  value to convert
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
out_mode  output  1  mode of the result's transaction
out_data  output  WIDTH  converted value
cnt_en  input  1  counter step enable
cnt_dir  input  1  1 = up, 0 = down
cnt_clr  input  1  synchronous clear to CNT_RESET
cnt_bin  output  WIDTH  counter binary value (registered)
cnt_gray  output  WIDTH  counter Gray value (registered)
cnt_wrap  output  1  one-cycle pulse on wrap

Behaviour:
- Reset (rst_n low, asynchronous):
  - Stage valids, out_valid, out_data, out_mode and cnt_wrap go to 0.
  - cnt_bin goes to CNT_RESET; cnt_gray goes to the Gray code of CNT_RESET.
  - Reset mid-transaction discards all in-flight data; nothing is replayed.
- Conversion rules:
  - Binary-to-Gray: g = b ^ (b >> 1).
  - Gray-to-binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i], for i from WIDTH-2 down to 0.
  - Pure bitwise; no overflow cases exist.
- Pipeline structure:
  - Two stages. S1 registers in_data and in_mode. S2 registers the converted result and mode; S2 drives out_data, out_valid and out_mode.
  - Latency is exactly 2 cycles from the accept edge to out_valid with no stall.
  - Throughput is 1 transaction per cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - Input is accepted on a rising edge when in_valid && in_ready.
  - When advance = 1, both stages shift: S1 valid <= in_valid and S2 valid <= S1 valid. Bubbles propagate as invalid entries.
  - When advance = 0, both stages hold. out_data and out_mode stay stable while out_valid && !out_ready.
  - Transfer out occurs on an edge with out_valid && out_ready.
  - Simultaneous accept and emit in the same cycle is legal.
  - in_data is ignored when in_valid = 0. Stage data registers may update on bubbles, but out_data is don't-care whenever out_valid = 0.
- Counter:
  - Independent of the pipeline and never stalled by out_ready.
  - Priority per edge: cnt_clr > cnt_en > hold.
  - cnt_clr: cnt_bin <= CNT_RESET and cnt_wrap <= 0.
  - cnt_en: cnt_bin <= cnt_bin + 1 (cnt_dir = 1) or cnt_bin - 1 (cnt_dir = 0), modulo 2^WIDTH.
  - cnt_gray is registered on the same edge as the Gray code of the next cnt_bin. Consecutive cnt_gray values differ in exactly one bit.
  - cnt_wrap <= 1 for one cycle when a step goes up from all-ones to 0 or down from 0 to all-ones; otherwise cnt_wrap <= 0.
  - Changing cnt_dir between steps is legal and takes effect on the next step.

Test Plan:
- WIDTH=4, reset, then one transaction mode 0 data 0110 with out_ready=1 -> out_valid high exactly 2 cycles after accept, out_data 0101, out_mode 0; in_ready stays 1.
- Back-to-back mode 1 stream 0101, 1000, 0000, 1111 with out_ready=1 -> results 0110, 1111, 0000, 1010 on consecutive cycles, no bubbles.
- Stall during a stream: hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data frozen, no transaction lost or duplicated; after release, output order equals input order.
- Counter up from reset (CNT_RESET=0), cnt_en=1, cnt_dir=1, 17 cycles:
  - cnt_gray sequence is 0000, 0001, 0011, 0010, ...
  - After 16 steps: cnt_bin=0000 and cnt_wrap pulses exactly once, on the 1111->0000 step.
  - Every adjacent gray pair has Hamming distance 1.
- Counter down from 0000 one step -> cnt_bin 1111, cnt_gray 1000, cnt_wrap=1 for one cycle. Then assert cnt_clr and cnt_en together -> cnt_bin=CNT_RESET and cnt_wrap=0.
- Assert rst_n low asynchronously mid-stream and mid-count -> out_valid=0 and cnt_bin=CNT_RESET immediately, without waiting for a clock edge; after release the first new input emerges at latency 2.

Source files
------------

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe
// -----------------------------------------------------------------------------
// Pipelined binary/Gray converter with a valid/ready handshake. The block also
// contains an independent up/down Gray-code counter for CDC pointers and test
// pattern generation.
//
// The converter has two register stages:
//   S1 holds the raw input word and its mode.
//   S2 holds the converted word and its mode, and drives the output port.
// Both stages shift together whenever the output slot is free or being drained.
// A result therefore appears two edges after its input is presented, and the
// pipeline sustains one transaction per cycle.
//
// Parameters:
//   WIDTH      data / counter width in bits (>= 2)
//   CNT_RESET  binary reset / clear value of the counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input transaction present
//   in_ready   block accepts input this cycle (combinational)
//   in_mode    0 = binary-to-Gray, 1 = Gray-to-binary
//   in_data    value to convert
//   out_valid  result present
//   out_ready  downstream accepts result
//   out_mode   mode of the result's transaction
//   out_data   converted value
//   cnt_en     counter step enable
//   cnt_dir    1 = count up, 0 = count down
//   cnt_clr    synchronous clear to CNT_RESET (wins over cnt_en)
//   cnt_bin    counter binary value (registered)
//   cnt_gray   counter Gray value (registered)
//   cnt_wrap   one-cycle pulse when a step wraps around
// -----------------------------------------------------------------------------
module gray_codec_pipe #(
    parameter int WIDTH     = 4,
    parameter int CNT_RESET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    input  logic             cnt_en,
    input  logic             cnt_dir,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] cnt_bin,
    output logic [WIDTH-1:0] cnt_gray,
    output logic             cnt_wrap
);

    localparam logic [WIDTH-1:0] CNT_RESET_BIN  = WIDTH'(CNT_RESET);
    localparam logic [WIDTH-1:0] CNT_RESET_GRAY = CNT_RESET_BIN ^ (CNT_RESET_BIN >> 1);
    localparam logic [WIDTH-1:0] CNT_ONE        = WIDTH'(1);

    // -------------------------------------------------------------------------
    // Pipeline control
    // -------------------------------------------------------------------------
    logic             advance;

    logic             s1_valid_reg;
    logic             s1_mode_reg;
    logic [WIDTH-1:0] s1_data_reg;

    logic             s2_valid_reg;
    logic             s2_mode_reg;
    logic [WIDTH-1:0] s2_data_reg;

    // The whole pipe moves as one unit. It may move whenever the output slot
    // is empty or its current content is taken this cycle.
    assign advance  = !s2_valid_reg || out_ready;
    assign in_ready = advance;

    // -------------------------------------------------------------------------
    // Conversion logic between S1 and S2
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] b2g_data;
    logic [WIDTH-1:0] g2b_data;
    logic [WIDTH-1:0] conv_data;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_conv
        // Binary-to-Gray: each bit XORs with its upper neighbour, and the MSB
        // passes through unchanged.
        if (gi == WIDTH - 1) begin : g_b2g_msb
            assign b2g_data[gi] = s1_data_reg[gi];
        end else begin : g_b2g_bit
            assign b2g_data[gi] = s1_data_reg[gi] ^ s1_data_reg[gi+1];
        end
        // Gray-to-binary: unrolling b[i] = b[i+1] ^ g[i] makes every binary
        // bit the parity of all Gray bits at or above it. Each bit is a
        // single XOR tree, so there is no ripple chain through bit positions.
        assign g2b_data[gi] = ^s1_data_reg[WIDTH-1:gi];
    end

    assign conv_data = s1_mode_reg ? g2b_data : b2g_data;

    // -------------------------------------------------------------------------
    // Stage registers
    // -------------------------------------------------------------------------
    // S1 data is captured even on bubbles. This is harmless because the valid
    // bit travels with it, and it saves a data-enable term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_data_reg  <= '0;
        end else if (advance) begin
            s1_valid_reg <= in_valid;
            s1_mode_reg  <= in_mode;
            s1_data_reg  <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_mode_reg  <= 1'b0;
            s2_data_reg  <= '0;
        end else if (advance) begin
            s2_valid_reg <= s1_valid_reg;
            s2_mode_reg  <= s1_mode_reg;
            s2_data_reg  <= conv_data;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_mode  = s2_mode_reg;
    assign out_data  = s2_data_reg;

    // -------------------------------------------------------------------------
    // Up/down Gray counter (never stalled by the pipeline)
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] cnt_bin_reg;
    logic [WIDTH-1:0] cnt_bin_next;
    logic [WIDTH-1:0] cnt_gray_reg;
    logic [WIDTH-1:0] cnt_gray_next;
    logic             cnt_wrap_reg;
    logic             cnt_wrap_next;

    always_comb begin
        cnt_bin_next  = cnt_bin_reg;
        cnt_wrap_next = 1'b0;
        if (cnt_clr) begin
            cnt_bin_next = CNT_RESET_BIN;
        end else if (cnt_en) begin
            if (cnt_dir) begin
                cnt_bin_next  = cnt_bin_reg + CNT_ONE;
                cnt_wrap_next = &cnt_bin_reg;
            end else begin
                cnt_bin_next  = cnt_bin_reg - CNT_ONE;
                cnt_wrap_next = ~|cnt_bin_reg;
            end
        end
    end

    // The Gray output is derived from the next binary value. This keeps both
    // registered outputs in step, and cnt_gray stays glitch-free for
    // cross-domain sampling.
    assign cnt_gray_next = cnt_bin_next ^ (cnt_bin_next >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_bin_reg  <= CNT_RESET_BIN;
            cnt_gray_reg <= CNT_RESET_GRAY;
            cnt_wrap_reg <= 1'b0;
        end else begin
            cnt_bin_reg  <= cnt_bin_next;
            cnt_gray_reg <= cnt_gray_next;
            cnt_wrap_reg <= cnt_wrap_next;
        end
    end

    assign cnt_bin  = cnt_bin_reg;
    assign cnt_gray = cnt_gray_reg;
    assign cnt_wrap = cnt_wrap_reg;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe
// -----------------------------------------------------------------------------
// Self-checking bench for gray_codec_pipe with WIDTH=4 and CNT_RESET=0.
// Expected conversion results come from a reference model. Binary-to-Gray uses
// plain arithmetic. Gray-to-binary is found by searching for the binary value
// whose Gray code matches. The model keeps a queue of expected results, filled
// on each accepted input and drained on each output transfer.
// -----------------------------------------------------------------------------
module tb_gray_codec_pipe;

    localparam int W = 4;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_mode;
    logic [W-1:0] out_data;
    logic         cnt_en;
    logic         cnt_dir;
    logic         cnt_clr;
    logic [W-1:0] cnt_bin;
    logic [W-1:0] cnt_gray;
    logic         cnt_wrap;

    int compared   = 0;
    int mismatched = 0;

    logic [W:0] exp_q[$];
    logic [W:0] mon_e;

    logic [W-1:0] s2_in  [4] = '{4'b0101, 4'b1000, 4'b0000, 4'b1111};
    logic [W-1:0] s2_exp [4] = '{4'b0110, 4'b1111, 4'b0000, 4'b1010};
    logic [W-1:0] g_first[3] = '{4'b0001, 4'b0011, 4'b0010};

    gray_codec_pipe #(.WIDTH(W), .CNT_RESET(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
        .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_clr(cnt_clr),
        .cnt_bin(cnt_bin), .cnt_gray(cnt_gray), .cnt_wrap(cnt_wrap)
    );

    always #5 clk = ~clk;

    // Reference model
    function automatic logic [W-1:0] m_b2g(input int b);
        return W'(b ^ (b / 2));
    endfunction

    function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
        for (int b = 0; b < M; b++)
            if (m_b2g(b) == g) return W'(b);
        return '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sample handshakes mid-cycle. The transfer then happens on
    // the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                exp_q.push_back({in_mode, in_mode ? m_g2b(in_data) : m_b2g(in_data)});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_transfer", {27'd0, out_mode, out_data}, {27'd0, mon_e});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int mb;
        int wraps;
        logic pw;
        logic fire;
        logic [W-1:0] prev_g;
        logic [W-1:0] frozen;
        logic [W-1:0] st_data[6];
        logic         st_mode[6];
        logic [W-1:0] d;

        rst_n = 1'b1; in_valid = 0; in_mode = 0; in_data = '0; out_ready = 1;
        cnt_en = 0; cnt_dir = 1; cnt_clr = 0;
        frozen = '0;
        #1 rst_n = 1'b0;
        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_cnt_bin", cnt_bin, 0);
        check("reset_cnt_gray", cnt_gray, 0);
        check("reset_cnt_wrap", cnt_wrap, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single binary-to-Gray transaction: 0110 -> 0101 two edges later
        in_valid = 1; in_mode = 0; in_data = 4'b0110;
        tick();
        in_valid = 0;
        check("single_lat1_valid", out_valid, 0);
        check("single_in_ready", in_ready, 1);
        tick();
        check("single_lat2_valid", out_valid, 1);
        check("single_data", out_data, 4'b0101);
        check("single_mode", out_mode, 0);
        check("single_in_ready2", in_ready, 1);
        tick();
        check("single_after_valid", out_valid, 0);

        // Back-to-back Gray-to-binary stream, no bubbles
        in_mode = 1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin in_valid = 1; in_data = s2_in[i]; end
            else in_valid = 0;
            tick();
            if (i >= 1 && i <= 4) begin
                check("stream_valid", out_valid, 1);
                check("stream_data", out_data, s2_exp[i-1]);
                check("stream_mode", out_mode, 1);
            end
        end

        // Stream with a three-cycle output stall
        for (int i = 0; i < 6; i++) begin
            st_data[i] = W'($urandom_range(0, M-1));
            st_mode[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            out_ready = !(c >= 3 && c < 6);
            if (idx < 6) begin in_valid = 1; in_data = st_data[idx]; in_mode = st_mode[idx]; end
            else in_valid = 0;
            #1;
            fire = in_valid && in_ready;
            if (c >= 3 && c < 6) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                if (c == 3) frozen = out_data;
                else check("stall_frozen", out_data, frozen);
            end
            @(posedge clk); #1;
            if (fire) idx++;
        end
        check("stall_all_accepted", idx, 6);
        in_valid = 0; out_ready = 1;
        repeat (4) tick();
        check("stall_drained", exp_q.size(), 0);

        // Random handshake traffic
        for (int c = 0; c < 200; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_mode   = 1'($urandom_range(0, 1));
            in_data   = W'($urandom_range(0, M-1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 0; out_ready = 1;
        repeat (4) tick();
        check("random_drained", exp_q.size(), 0);

        // Counter up 17 steps from reset value
        check("cnt_start", cnt_bin, 0);
        mb = 0; wraps = 0; prev_g = cnt_gray;
        cnt_en = 1; cnt_dir = 1;
        for (int s = 1; s <= 17; s++) begin
            tick();
            pw = (mb == M - 1);
            mb = (mb + 1) % M;
            check("up_bin", cnt_bin, mb);
            check("up_gray", cnt_gray, m_b2g(mb));
            check("up_wrap", cnt_wrap, pw);
            check("up_hamming", $countones(prev_g ^ cnt_gray), 1);
            if (s <= 3) check("up_gray_seq", cnt_gray, g_first[s-1]);
            if (s == 16) check("up_bin_after16", cnt_bin, 0);
            wraps += int'(cnt_wrap);
            prev_g = cnt_gray;
        end
        check("up_wrap_count", wraps, 1);

        // Clear, one step down through zero, then clear racing an up-wrap
        cnt_en = 0; cnt_clr = 1;
        tick();
        cnt_clr = 0;
        check("clr_bin", cnt_bin, 0);
        check("clr_wrap", cnt_wrap, 0);
        cnt_en = 1; cnt_dir = 0;
        tick();
        check("down_bin", cnt_bin, 4'b1111);
        check("down_gray", cnt_gray, 4'b1000);
        check("down_wrap", cnt_wrap, 1);
        cnt_clr = 1; cnt_en = 1; cnt_dir = 1;
        tick();
        check("clr_en_bin", cnt_bin, 0);
        check("clr_en_gray", cnt_gray, 0);
        check("clr_en_wrap", cnt_wrap, 0);
        cnt_clr = 0; cnt_en = 0;
        tick();
        check("hold_bin", cnt_bin, 0);
        check("hold_wrap", cnt_wrap, 0);

        // Random counter operation
        mb = 0;
        for (int c = 0; c < 150; c++) begin
            cnt_clr = ($urandom_range(0, 15) == 0);
            cnt_en  = 1'($urandom_range(0, 1));
            cnt_dir = 1'($urandom_range(0, 1));
            pw = 0;
            if (cnt_clr) mb = 0;
            else if (cnt_en) begin
                if (cnt_dir) begin pw = (mb == M - 1); mb = (mb + 1) % M; end
                else begin pw = (mb == 0); mb = (mb + M - 1) % M; end
            end
            tick();
            check("rnd_cnt_bin", cnt_bin, mb);
            check("rnd_cnt_gray", cnt_gray, m_b2g(mb));
            check("rnd_cnt_wrap", cnt_wrap, pw);
        end
        cnt_clr = 1; cnt_en = 0;
        tick();
        cnt_clr = 0;

        // Asynchronous reset mid-stream and mid-count
        out_ready = 1; in_valid = 1; in_mode = 0; cnt_en = 1; cnt_dir = 1;
        for (int c = 0; c < 3; c++) begin
            in_data = W'($urandom_range(0, M-1));
            tick();
        end
        check("pre_reset_valid", out_valid, 1);
        check("pre_reset_cnt", cnt_bin, 3);
        in_valid = 0; cnt_en = 0;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_cnt_bin", cnt_bin, 0);
        check("async_cnt_gray", cnt_gray, 0);
        check("async_cnt_wrap", cnt_wrap, 0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        d = W'($urandom_range(0, M-1));
        in_valid = 1; in_mode = 1; in_data = d;
        tick();
        in_valid = 0;
        check("post_reset_lat1", out_valid, 0);
        tick();
        check("post_reset_lat2", out_valid, 1);
        check("post_reset_data", out_data, m_g2b(d));
        check("post_reset_mode", out_mode, 1);
        check("post_reset_cnt", cnt_bin, 0);
        tick();
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
